// File: rtl/qmem_sram16_if.sv
// QMEM request/response bundle between the control-CPU interconnect and a QMEM slave.
interface qmem_sram16_if #(
  parameter int QAW = 22,
  parameter int QDW = 32,
  parameter int QSW = 4
);
  logic           cs;
  logic           we;
  logic [QSW-1:0] sel;
  logic [QAW-1:0] adr;
  logic [QDW-1:0] dat_w;
  logic [QDW-1:0] dat_r;
  logic           ack;
  logic           err;

  modport master (output cs, we, sel, adr, dat_w, input  dat_r, ack, err);
  modport slave  (input  cs, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/qmem_sram16.sv
// QMEM slave to 16-bit async SRAM bridge: each 32-bit access becomes up to two
// big-endian halfword cycles (even halfword = bits [31:16]) with WAIT wait states.
module qmem_sram16 #(
  parameter int QAW  = 22,
  parameter int QDW  = 32,
  parameter int QSW  = 4,
  parameter int SAW  = 21,
  parameter int WAIT = 2
) (
  input  logic           clk,
  input  logic           rst,
  qmem_sram16_if.slave   qs,
  output logic [SAW-1:0] sram_adr,
  output logic [15:0]    sram_dq_o,
  output logic           sram_dq_oe,
  input  logic [15:0]    sram_dq_i,
  output logic           sram_ce_n,
  output logic           sram_oe_n,
  output logic           sram_we_n,
  output logic           sram_ub_n,
  output logic           sram_lb_n
);
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_H0, S_H1, S_ACK} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           su_q, su_d;
  logic           we_q, we_d;
  logic [QSW-1:0] sel_q, sel_d;
  logic [QAW-3:0] adr_q, adr_d;
  logic [QDW-1:0] dat_q, dat_d;
  logic [QDW-1:0] rbuf_q, rbuf_d;
  logic [QDW-1:0] dat_r_q, dat_r_d;
  logic           ack_q, ack_d, err_q, err_d;
  logic [SAW-1:0] sram_adr_q, sram_adr_d;
  logic [15:0]    dq_o_q, dq_o_d;
  logic           dq_oe_q, dq_oe_d;
  logic           ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic           ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic           in_ph, hi;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    su_d       = su_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rbuf_d     = rbuf_q;
    dat_r_d    = dat_r_q;
    sram_adr_d = sram_adr_q;
    dq_o_d     = dq_o_q;
    case (state_q)
      S_IDLE: if (qs.cs) begin
        we_d   = qs.we;
        sel_d  = qs.sel;
        adr_d  = qs.adr[QAW-1:2];
        dat_d  = qs.dat_w;
        // Seed from dat_r so a skipped halfword keeps its previous read value.
        rbuf_d = dat_r_q;
        if (|qs.sel[3:2])      state_d = S_H0;
        else if (|qs.sel[1:0]) state_d = S_H1;
        else                   state_d = S_ACK;
      end
      S_H0, S_H1: begin
        if (su_q) su_d = 1'b0;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          if (!we_q) begin
            if (state_q == S_H0) rbuf_d[31:16] = sram_dq_i;
            else                 rbuf_d[15:0]  = sram_dq_i;
          end
          state_d = (state_q == S_H0 && |sel_q[1:0]) ? S_H1 : S_ACK;
        end
      end
      S_ACK: begin
        if (!we_q) dat_r_d = rbuf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Writes get an extra setup cycle ahead of the WAIT strobe cycles.
    if ((state_d == S_H0 || state_d == S_H1) && state_d != state_q) begin
      cnt_d = WAIT_C;
      su_d  = we_d;
    end

    // Pad outputs are registered from next-state values so they are glitch-free.
    in_ph   = (state_d == S_H0) || (state_d == S_H1);
    hi      = (state_d == S_H0);
    ce_n_d  = !in_ph;
    oe_n_d  = !(in_ph && !we_d);
    we_n_d  = !(in_ph && we_d && !su_d && cnt_d != 4'd0);
    dq_oe_d = in_ph && we_d;
    ub_n_d  = !(in_ph && (hi ? sel_d[3] : sel_d[1]));
    lb_n_d  = !(in_ph && (hi ? sel_d[2] : sel_d[0]));
    if (in_ph) begin
      sram_adr_d = {adr_d, ~hi};
      dq_o_d     = hi ? dat_d[31:16] : dat_d[15:0];
    end
    ack_d = (state_d == S_ACK);
    err_d = (state_d == S_ACK) && (sel_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      su_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      rbuf_q     <= '0;
      dat_r_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      sram_adr_q <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      su_q       <= su_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rbuf_q     <= rbuf_d;
      dat_r_q    <= dat_r_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      sram_adr_q <= sram_adr_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
    end
  end

  assign qs.dat_r    = dat_r_q;
  assign qs.ack      = ack_q;
  assign qs.err      = err_q;
  assign sram_adr    = sram_adr_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;
endmodule

// File: tb/tb_qmem_sram16.sv
// Bench for qmem_sram16: SRAM device model on the pads, word-level reference memory
// and expected read register kept in the bench.
module tb_qmem_sram16;
  localparam int QAW = 22, QDW = 32, QSW = 4, SAW = 21, WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qmem_sram16_if #(.QAW(QAW), .QDW(QDW), .QSW(QSW)) qs ();

  logic [SAW-1:0] sram_adr;
  logic [15:0]    sram_dq_o, sram_dq_i;
  logic           sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  qmem_sram16 #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .SAW(SAW), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .qs(qs),
    .sram_adr(sram_adr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  // SRAM device: 32 halfwords, byte-lane writes while we_n is low
  logic [15:0] smem [0:31];
  always_comb begin
    sram_dq_i = 16'h0;
    if (!sram_ce_n && !sram_oe_n) sram_dq_i = smem[sram_adr[4:0]];
  end
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) smem[sram_adr[4:0]][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) smem[sram_adr[4:0]][7:0]  <= sram_dq_o[7:0];
    end
  end

  // Pad activity monitor
  int ce_lo = 0, we_lo = 0, we_pulses = 0, viol = 0, ack_seen = 0, wwidth = 0;
  logic prev_we_n = 1'b1, prev_oe = 1'b0;
  logic [15:0] prev_dq = '0;
  logic [SAW-1:0] prev_adr = '0;
  always @(negedge clk) begin
    if (!rst) wwidth = 0;
    else begin
      if (!sram_we_n) begin
        we_lo++; wwidth++;
        if (prev_we_n) we_pulses++;
      end else if (!prev_we_n) begin
        if (wwidth != WAIT) viol++;
        wwidth = 0;
      end
      if (!sram_we_n && (!sram_oe_n || !sram_dq_oe || sram_ce_n)) viol++;
      if (sram_dq_oe && prev_oe && sram_adr == prev_adr && sram_dq_o != prev_dq) viol++;
    end
    if (!sram_ce_n) ce_lo++;
    if (qs.ack) ack_seen++;
    prev_we_n = sram_we_n;
    prev_oe   = sram_dq_oe;
    prev_dq   = sram_dq_o;
    prev_adr  = sram_adr;
  end

  typedef struct {
    int          lat;
    logic        err;
    logic        ack_after;
    logic [31:0] dat;
    int          ce, we, pulses, acks;
  } obs_t;

  int total = 0, bad = 0;
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_r = '0;

  function automatic int exp_lat(input logic w, input logic [3:0] s);
    int hp = int'(|s[3:2]) + int'(|s[1:0]);
    return hp * (w ? WAIT + 2 : WAIT + 1);
  endfunction

  function automatic int halves(input logic [3:0] s);
    return int'(|s[3:2]) + int'(|s[1:0]);
  endfunction

  // Reference model update for one completed access
  task automatic ref_apply(input logic w, input logic [21:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      if (|s[3:2]) exp_r[31:16] = ref_mem[a[5:2]][31:16];
      if (|s[1:0]) exp_r[15:0]  = ref_mem[a[5:2]][15:0];
    end
  endtask

  // Drive one request, measure cycles from the sampling edge to ack, report observations
  task automatic run_access(input logic w, input logic [21:0] a, input logic [3:0] s,
                            input logic [31:0] d, input logic release_rst, output obs_t o);
    int ce0, we0, p0, a0;
    @(negedge clk);
    qs.cs = 1'b1; qs.we = w; qs.adr = a; qs.sel = s; qs.dat_w = d;
    if (release_rst) rst = 1'b1;
    ce0 = ce_lo; we0 = we_lo; p0 = we_pulses; a0 = ack_seen;
    @(posedge clk);
    o.lat = 0;
    while (1) begin
      @(negedge clk);
      if (qs.ack) break;
      o.lat++;
      if (o.lat > 60) break;
    end
    o.err = qs.err;
    qs.cs = 1'b0;
    @(negedge clk);
    o.ack_after = qs.ack;
    o.dat       = qs.dat_r;
    o.ce        = ce_lo - ce0;
    o.we        = we_lo - we0;
    o.pulses    = we_pulses - p0;
    o.acks      = ack_seen - a0;
  endtask

  task automatic test_reset();
    obs_t o;
    qs.cs = 1'b1; qs.we = 1'b1; qs.adr = 22'h20; qs.sel = 4'hF; qs.dat_w = 32'h12345678;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (qs.ack !== 1'b0 || qs.err !== 1'b0) begin
      bad++; $display("FAIL reset_ack ack=%b err=%b need 0 0", qs.ack, qs.err);
    end
    total++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      bad++; $display("FAIL reset_strobes got=%b need 11111",
                      {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    total++;
    if (sram_dq_oe !== 1'b0 || sram_adr !== '0 || sram_dq_o !== 16'h0 || qs.dat_r !== 32'h0) begin
      bad++; $display("FAIL reset_regs oe=%b adr=%h dq=%h dat_r=%h need all 0",
                      sram_dq_oe, sram_adr, sram_dq_o, qs.dat_r);
    end
    run_access(1'b1, 22'h20, 4'hF, 32'h12345678, 1'b1, o);
    ref_apply(1'b1, 22'h20, 4'hF, 32'h12345678);
    total++;
    if (o.lat !== 8) begin bad++; $display("FAIL reset_release_lat got=%0d need 8", o.lat); end
  endtask

  task automatic test_fill();
    obs_t o;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run_access(1'b1, 22'(i * 4), 4'hF, d, 1'b0, o);
      ref_apply(1'b1, 22'(i * 4), 4'hF, d);
      total++;
      if (o.lat !== 8 || o.acks !== 1) begin
        bad++; $display("FAIL fill_%0d lat=%0d acks=%0d need 8 1", i, o.lat, o.acks);
      end
    end
  endtask

  task automatic test_write();
    obs_t o;
    run_access(1'b1, 22'h10, 4'hF, 32'hDEADBEEF, 1'b0, o);
    ref_apply(1'b1, 22'h10, 4'hF, 32'hDEADBEEF);
    total++;
    if (o.lat !== 8 || o.err !== 1'b0) begin
      bad++; $display("FAIL write_lat lat=%0d err=%b need 8 0", o.lat, o.err);
    end
    total++;
    if (o.pulses !== 2 || o.we !== 2 * WAIT) begin
      bad++; $display("FAIL write_strobe pulses=%0d we_cycles=%0d need 2 %0d", o.pulses, o.we, 2 * WAIT);
    end
    total++;
    if (o.acks !== 1 || o.ack_after !== 1'b0) begin
      bad++; $display("FAIL write_ack acks=%0d ack_after=%b need 1 0", o.acks, o.ack_after);
    end
    total++;
    if (smem[8] !== 16'hDEAD || smem[9] !== 16'hBEEF) begin
      bad++; $display("FAIL write_sram h8=%h h9=%h need dead beef", smem[8], smem[9]);
    end
  endtask

  task automatic test_read();
    obs_t o;
    run_access(1'b0, 22'h10, 4'hF, 32'h0, 1'b0, o);
    ref_apply(1'b0, 22'h10, 4'hF, 32'h0);
    total++;
    if (o.lat !== 6) begin bad++; $display("FAIL read_lat got=%0d need 6", o.lat); end
    total++;
    if (o.dat !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h need deadbeef", o.dat); end
    total++;
    if (o.we !== 0 || o.ce !== 6) begin
      bad++; $display("FAIL read_strobe we=%0d ce=%0d need 0 6", o.we, o.ce);
    end
  endtask

  task automatic test_partial();
    obs_t o;
    run_access(1'b1, 22'h10, 4'b0010, 32'h0000AA00, 1'b0, o);
    ref_apply(1'b1, 22'h10, 4'b0010, 32'h0000AA00);
    total++;
    if (o.lat !== WAIT + 2 || o.pulses !== 1) begin
      bad++; $display("FAIL partial_write lat=%0d pulses=%0d need %0d 1", o.lat, o.pulses, WAIT + 2);
    end
    total++;
    if (smem[8] !== 16'hDEAD || smem[9] !== 16'hAAEF) begin
      bad++; $display("FAIL partial_sram h8=%h h9=%h need dead aaef", smem[8], smem[9]);
    end
    run_access(1'b0, 22'h10, 4'hF, 32'h0, 1'b0, o);
    ref_apply(1'b0, 22'h10, 4'hF, 32'h0);
    total++;
    if (o.dat !== 32'hDEADAAEF) begin bad++; $display("FAIL partial_read got=%h need deadaaef", o.dat); end
  endtask

  task automatic test_err();
    obs_t o;
    run_access(1'b0, 22'h14, 4'h0, 32'h0, 1'b0, o);
    total++;
    if (o.lat !== 0 || o.err !== 1'b1) begin
      bad++; $display("FAIL err_ack lat=%0d err=%b need 0 1", o.lat, o.err);
    end
    total++;
    if (o.ce !== 0 || o.dat !== exp_r) begin
      bad++; $display("FAIL err_quiet ce=%0d dat=%h need 0 %h", o.ce, o.dat, exp_r);
    end
  endtask

  task automatic test_rst_mid();
    obs_t o;
    int a0;
    logic [31:0] d = 32'hCAFE1234;
    @(negedge clk);
    qs.cs = 1'b1; qs.we = 1'b1; qs.adr = 22'h14; qs.sel = 4'hF; qs.dat_w = d;
    a0 = ack_seen;
    @(posedge clk);
    repeat (6) @(negedge clk);
    total++;
    if (sram_we_n !== 1'b0 || sram_adr !== 21'hB) begin
      bad++; $display("FAIL rstmid_phase we_n=%b adr=%h need 0 b", sram_we_n, sram_adr);
    end
    qs.cs = 1'b0;
    #1 rst = 1'b0;
    #1;
    total++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1) begin
      bad++; $display("FAIL rstmid_strobes we_n=%b oe=%b ce_n=%b need 1 0 1", sram_we_n, sram_dq_oe, sram_ce_n);
    end
    repeat (4) @(negedge clk);
    total++;
    if (ack_seen !== a0) begin bad++; $display("FAIL rstmid_noack acks=%0d need 0", ack_seen - a0); end
    // H0 half completed before reset; H1 never got a write strobe edge.
    ref_mem[5][31:16] = d[31:16];
    exp_r = '0;
    run_access(1'b1, 22'h18, 4'hF, 32'h0BADF00D, 1'b1, o);
    ref_apply(1'b1, 22'h18, 4'hF, 32'h0BADF00D);
    run_access(1'b0, 22'h18, 4'hF, 32'h0, 1'b0, o);
    ref_apply(1'b0, 22'h18, 4'hF, 32'h0);
    total++;
    if (o.dat !== exp_r || o.lat !== 6) begin
      bad++; $display("FAIL rstmid_after dat=%h lat=%0d need %h 6", o.dat, o.lat, exp_r);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic w;
    logic [3:0] s;
    logic [21:0] a;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      a = 22'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      d = $urandom;
      run_access(w, a, s, d, 1'b0, o);
      ref_apply(w, a, s, d);
      total++;
      if (o.lat !== exp_lat(w, s) || o.err !== (s == 4'h0) || o.acks !== 1) begin
        bad++; $display("FAIL rand_%0d_timing lat=%0d err=%b acks=%0d need %0d %b 1",
                        i, o.lat, o.err, o.acks, exp_lat(w, s), (s == 4'h0));
      end
      total++;
      if (o.dat !== exp_r || o.pulses !== (w ? halves(s) : 0)) begin
        bad++; $display("FAIL rand_%0d_data dat=%h pulses=%0d need %h %0d",
                        i, o.dat, o.pulses, exp_r, (w ? halves(s) : 0));
      end
    end
    // Final sweep reads every word back against the reference
    for (int i = 0; i < 16; i++) begin
      run_access(1'b0, 22'(i * 4), 4'hF, 32'h0, 1'b0, o);
      ref_apply(1'b0, 22'(i * 4), 4'hF, 32'h0);
      total++;
      if (o.dat !== ref_mem[i]) begin
        bad++; $display("FAIL sweep_%0d got=%h need %h", i, o.dat, ref_mem[i]);
      end
    end
  endtask

  task automatic test_protocol();
    total++;
    if (viol !== 0) begin bad++; $display("FAIL pad_protocol violations=%0d need 0", viol); end
  endtask

  initial begin
    qs.cs = 1'b0; qs.we = 1'b0; qs.adr = '0; qs.sel = '0; qs.dat_w = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    test_reset();
    test_fill();
    test_write();
    test_read();
    test_partial();
    test_err();
    test_rst_mid();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
